// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict/resolve unit.
//  - funct3 encodings of the RV32 conditional branches
//  - 2-bit saturating direction counter type and its update function
package branch_pkg;

  localparam logic [2:0] Beq  = 3'b000;
  localparam logic [2:0] Bne  = 3'b001;
  localparam logic [2:0] Blt  = 3'b100;
  localparam logic [2:0] Bge  = 3'b101;
  localparam logic [2:0] Bltu = 3'b110;
  localparam logic [2:0] Bgeu = 3'b111;

  typedef logic [1:0] ctr_t;

  // Saturating step toward taken (max 2'b11) or not-taken (min 2'b00).
  function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// RV32 conditional branch comparator, purely combinational.
//  funct3_i  : branch type
//  a_i, b_i  : rs1 / rs2 operands
//  taken_o   : condition holds
//  illegal_o : funct3 is not a branch encoding (010/011); taken_o is 0 then
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            taken_o,
  output logic            illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      Beq:     taken_o = (a_i == b_i);
      Bne:     taken_o = (a_i != b_i);
      Blt:     taken_o = ($signed(a_i) < $signed(b_i));
      Bge:     taken_o = ($signed(a_i) >= $signed(b_i));
      Bltu:    taken_o = (a_i < b_i);
      Bgeu:    taken_o = (a_i >= b_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: bimodal BHT + direct-mapped BTB prediction at IF, condition evaluation,
// mispredict detection, table training and perf counters at EX.
//  clk, rst            : clock, asynchronous active-high reset
//  if_valid_i, if_pc_i : IF lookup request
//  pred_taken_o        : predicted taken (needs BTB hit and counter msb)
//  pred_target_o       : predicted next PC (BTB target or if_pc+4)
//  ex_*_i              : resolving branch from EX, with its IF prediction piped down
//  ex_taken_o          : actual direction
//  ex_illegal_o        : funct3 is not a branch encoding
//  mispredict_o        : redirect required, redirect_pc_o is the correct next PC
//  stat_branches_o     : resolved branches (saturating)
//  stat_mispred_o      : mispredicts (saturating)
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              ex_valid_i,
  input  logic              ex_is_branch_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   ex_a_i,
  input  logic [XLEN-1:0]   ex_b_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [XLEN-1:0]   ex_pred_target_i,
  output logic              ex_taken_o,
  output logic              ex_illegal_o,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int unsigned BhtIdxW = $clog2(BHT_ENTRIES);
  localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW    = XLEN - BtbIdxW - 2;

  // Tables are plain flops so reset clears them exactly.
  ctr_t              bht_q        [BHT_ENTRIES];
  logic              btb_valid_q  [BTB_ENTRIES];
  logic [TagW-1:0]   btb_tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]   btb_target_q [BTB_ENTRIES];
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

  // IF lookup
  logic [BhtIdxW-1:0] if_bht_idx;
  logic [BtbIdxW-1:0] if_btb_idx;
  logic [TagW-1:0]    if_tag;
  logic               if_hit;

  assign if_bht_idx = if_pc_i[BhtIdxW+1:2];
  assign if_btb_idx = if_pc_i[BtbIdxW+1:2];
  assign if_tag     = if_pc_i[XLEN-1:BtbIdxW+2];
  assign if_hit     = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);

  // Reads the registered tables only, so a same-cycle update is not bypassed.
  assign pred_taken_o  = if_valid_i && if_hit && bht_q[if_bht_idx][1];
  assign pred_target_o = pred_taken_o ? btb_target_q[if_btb_idx] : if_pc_i + XLEN'(4);

  // EX resolution
  logic               cond_taken;
  logic               res;
  logic [BhtIdxW-1:0] ex_bht_idx;
  logic [BtbIdxW-1:0] ex_btb_idx;
  logic [TagW-1:0]    ex_tag;
  logic [XLEN-1:0]    ex_pc_plus4;

  branch_cond_eval #(
    .XLEN(XLEN)
  ) u_cond (
    .funct3_i (ex_funct3_i),
    .a_i      (ex_a_i),
    .b_i      (ex_b_i),
    .taken_o  (cond_taken),
    .illegal_o(ex_illegal_o)
  );

  assign ex_taken_o  = cond_taken;
  assign res         = ex_valid_i && ex_is_branch_i && !ex_illegal_o;
  assign ex_bht_idx  = ex_pc_i[BhtIdxW+1:2];
  assign ex_btb_idx  = ex_pc_i[BtbIdxW+1:2];
  assign ex_tag      = ex_pc_i[XLEN-1:BtbIdxW+2];
  assign ex_pc_plus4 = ex_pc_i + XLEN'(4);

  always_comb begin
    mispredict_o  = 1'b0;
    redirect_pc_o = ex_pc_plus4;
    if (res) begin
      if (cond_taken && (!ex_pred_taken_i || (ex_pred_target_i != ex_target_i))) begin
        mispredict_o  = 1'b1;
        redirect_pc_o = ex_target_i;
      end else if (!cond_taken && ex_pred_taken_i) begin
        mispredict_o = 1'b1;
      end
    end
  end

  // Saturating perf counters
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (res && (stat_branches_q != '1)) stat_branches_d = stat_branches_q + STAT_W'(1);
    if (res && mispredict_o && (stat_mispred_q != '1)) begin
      stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
      if (res) begin
        bht_q[ex_bht_idx] <= ctr_update(bht_q[ex_bht_idx], cond_taken);
        // Not-taken leaves the BTB alone; the counter alone suppresses the prediction.
        if (cond_taken) begin
          btb_valid_q[ex_btb_idx]  <= 1'b1;
          btb_tag_q[ex_btb_idx]    <= ex_tag;
          btb_target_q[ex_btb_idx] <= ex_target_i;
        end
      end
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAT_W = 4;

  logic              clk;
  logic              rst;
  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              ex_valid;
  logic              ex_is_branch;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [2:0]        ex_funct3;
  logic [XLEN-1:0]   ex_target;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   ex_pred_target;
  logic              ex_taken;
  logic              ex_illegal;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  int n_total;
  int n_bad;

  branch_predict_unit #(
    .XLEN       (XLEN),
    .BHT_ENTRIES(64),
    .BTB_ENTRIES(16),
    .CTR_INIT   (2'b01),
    .STAT_W     (STAT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid_i      (if_valid),
    .if_pc_i         (if_pc),
    .pred_taken_o    (pred_taken),
    .pred_target_o   (pred_target),
    .ex_valid_i      (ex_valid),
    .ex_is_branch_i  (ex_is_branch),
    .ex_pc_i         (ex_pc),
    .ex_a_i          (ex_a),
    .ex_b_i          (ex_b),
    .ex_funct3_i     (ex_funct3),
    .ex_target_i     (ex_target),
    .ex_pred_taken_i (ex_pred_taken),
    .ex_pred_target_i(ex_pred_target),
    .ex_taken_o      (ex_taken),
    .ex_illegal_o    (ex_illegal),
    .mispredict_o    (mispredict),
    .redirect_pc_o   (redirect_pc),
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [XLEN-1:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    #1;
  endtask

  task automatic drive_ex(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [2:0] f3,
                          input logic [XLEN-1:0] tgt, input logic pt,
                          input logic [XLEN-1:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_a           = a;
    ex_b           = b;
    ex_funct3      = f3;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    if_valid = 1'b0; if_pc = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_a = '0; ex_b = '0;
    ex_funct3 = 3'b000; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

    // Reset state
    #3;
    lookup(32'h100);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_target", pred_target, 32'h104);
    check("rst_mispredict", mispredict, 0);
    check("rst_stat_br", stat_branches, 0);
    check("rst_stat_mp", stat_mispred, 0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ 5==5 predicted NT: mispredict to target; same-cycle lookup sees old state
    step();
    lookup(32'h100);
    drive_ex(32'h100, 5, 5, 3'b000, 32'h140, 1'b0, 32'h104);
    check("beq_taken", ex_taken, 1);
    check("beq_illegal", ex_illegal, 0);
    check("beq_mispredict", mispredict, 1);
    check("beq_redirect", redirect_pc, 32'h140);
    check("beq_same_cyc_pred", pred_taken, 0);
    step();
    ex_idle();
    check("beq_next_pred", pred_taken, 1);
    check("beq_next_target", pred_target, 32'h140);
    check("beq_stat_br", stat_branches, 1);
    check("beq_stat_mp", stat_mispred, 1);

    // Three correct taken resolutions: ctr 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      drive_ex(32'h100, 7, 7, 3'b000, 32'h140, 1'b1, 32'h140);
      check("tk_no_mispredict", mispredict, 0);
      check("tk_redirect_seq", redirect_pc, 32'h104);
      step();
    end
    // One not-taken while predicted taken: ctr 11 -> 10
    drive_ex(32'h100, 5, 6, 3'b000, 32'h140, 1'b1, 32'h140);
    check("nt_taken", ex_taken, 0);
    check("nt_mispredict", mispredict, 1);
    check("nt_redirect", redirect_pc, 32'h104);
    step();
    ex_idle();
    check("nt_still_pred", pred_taken, 1);
    check("nt_still_target", pred_target, 32'h140);
    check("nt_stat_br", stat_branches, 5);
    check("nt_stat_mp", stat_mispred, 2);
    // Taken again, correctly predicted
    drive_ex(32'h100, 1, 1, 3'b000, 32'h140, 1'b1, 32'h140);
    check("tk2_no_mispredict", mispredict, 0);
    // Taken with wrong predicted target
    ex_pred_target = 32'h180;
    #1;
    check("wrong_tgt_mispredict", mispredict, 1);
    check("wrong_tgt_redirect", redirect_pc, 32'h140);
    ex_pred_target = 32'h140;
    #1;
    step();   // ctr 10 -> 11; br=6 mp=2
    ex_idle();

    // Condition evaluation (no resolution while ex_valid=0)
    ex_a = 32'hFFFF_FFFF; ex_b = 32'h1;
    ex_funct3 = 3'b100; #1; check("blt_neg", ex_taken, 1);
    ex_funct3 = 3'b110; #1; check("bltu_big", ex_taken, 0);
    ex_funct3 = 3'b101; #1; check("bge_neg", ex_taken, 0);
    ex_funct3 = 3'b111; #1; check("bgeu_big", ex_taken, 1);
    ex_funct3 = 3'b001; #1; check("bne_diff", ex_taken, 1);

    // Illegal funct3 with a live predicted-taken branch: no mispredict, no stats
    drive_ex(32'h100, 5, 5, 3'b010, 32'h140, 1'b1, 32'h140);
    check("ill_flag", ex_illegal, 1);
    check("ill_taken", ex_taken, 0);
    check("ill_mispredict", mispredict, 0);
    step();
    ex_funct3 = 3'b011;
    #1;
    check("ill011_flag", ex_illegal, 1);
    step();
    ex_idle();
    check("ill_stat_br", stat_branches, 6);
    check("ill_stat_mp", stat_mispred, 2);

    // Alias: 0x140 shares BTB index with 0x100 but tag differs
    lookup(32'h140);
    check("alias_pred", pred_taken, 0);
    check("alias_target", pred_target, 32'h144);
    lookup(32'h100);
    check("alias_orig_pred", pred_taken, 1);

    // Same-cycle IF lookup and EX update on 0x308
    lookup(32'h308);
    drive_ex(32'h308, 3, 3, 3'b000, 32'h400, 1'b0, 32'h30C);
    check("same_old_pred", pred_taken, 0);
    step();
    ex_idle();
    check("same_new_pred", pred_taken, 1);
    check("same_new_target", pred_target, 32'h400);
    drive_ex(32'h308, 3, 4, 3'b000, 32'h400, 1'b1, 32'h400);
    check("same2_old_pred", pred_taken, 1);
    step();
    ex_idle();
    check("same2_new_pred", pred_taken, 0);
    check("same_stat_br", stat_branches, 8);
    check("same_stat_mp", stat_mispred, 4);

    // Stall: branch inputs present but ex_valid low
    ex_is_branch = 1'b1; ex_funct3 = 3'b000; ex_a = 1; ex_b = 1;
    step();
    check("stall_stat_br", stat_branches, 8);
    check("stall_mispred_out", mispredict, 0);

    // Drive stats to saturation with mispredicting not-taken branches at 0x50C
    for (int i = 0; i < 14; i++) begin
      drive_ex(32'h50C, 1, 2, 3'b000, 32'h600, 1'b1, 32'h600);
      step();
    end
    ex_idle();
    check("sat_stat_br", stat_branches, 15);
    check("sat_stat_mp", stat_mispred, 15);
    drive_ex(32'h50C, 1, 2, 3'b000, 32'h600, 1'b1, 32'h600);
    step();
    ex_idle();
    check("sat_hold_br", stat_branches, 15);
    check("sat_hold_mp", stat_mispred, 15);

    // Asynchronous reset mid-cycle with trained tables
    #2;
    rst = 1'b1;
    #1;
    lookup(32'h100);
    check("mrst_pred_100", pred_taken, 0);
    lookup(32'h308);
    check("mrst_pred_308", pred_taken, 0);
    check("mrst_stat_br", stat_branches, 0);
    check("mrst_stat_mp", stat_mispred, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    lookup(32'h100);
    check("post_rst_pred", pred_taken, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
